// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexed 7-segment driver fed by packed BCD, frame-synchronous display update
//   sclk     : system clock, rising edge
//   s_rst    : synchronous active-high reset
//   bcd_vld  : one-cycle strobe qualifying bcd_data
//   bcd_data : packed BCD, nibble 0 = least significant digit
//   sel      : active-low digit enable, one-hot-zero while scanning
//   seg      : active-low segments, seg[6:0] = g..a, seg[7] = dp (always off)
//   Optional: define BCD_SEG_LZ_BLANK_EN to blank leading zero digits
module bcd_seg_scan #(
  parameter int DIG_NUM  = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 sclk,
  input  logic                 s_rst,
  input  logic                 bcd_vld,
  input  logic [4*DIG_NUM-1:0] bcd_data,
  output logic [DIG_NUM-1:0]   sel,
  output logic [7:0]           seg
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
`ifdef BCD_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  typedef enum logic {BLANK, SHOW} state_t;
  state_t               r_state;
  logic [DW-1:0]        r_div_cnt;
  logic [IW-1:0]        r_dig_idx;
  logic [4*DIG_NUM-1:0] r_shadow;
  logic [4*DIG_NUM-1:0] r_disp;
  logic                 r_pend;
  logic                 w_div_end;
  logic                 w_last_dig;
  logic [3:0]           w_nib;
  logic                 w_blank;
  logic                 w_acc;
  logic [DIG_NUM-1:0]   w_sel;
  function automatic logic [7:0] f_dec(input logic [3:0] n);
    case (n)
      4'd0:    f_dec = 8'hC0;
      4'd1:    f_dec = 8'hF9;
      4'd2:    f_dec = 8'hA4;
      4'd3:    f_dec = 8'hB0;
      4'd4:    f_dec = 8'h99;
      4'd5:    f_dec = 8'h92;
      4'd6:    f_dec = 8'h82;
      4'd7:    f_dec = 8'hF8;
      4'd8:    f_dec = 8'h80;
      4'd9:    f_dec = 8'h90;
      default: f_dec = 8'hBF;
    endcase
  endfunction
  assign w_div_end  = r_div_cnt == DW'(SCAN_DIV - 1);
  assign w_last_dig = r_dig_idx == IW'(DIG_NUM - 1);
  // Walk from the top digit down so w_acc tells whether any nibble at or above i is non-zero.
  always_comb begin
    w_nib   = '0;
    w_blank = 1'b0;
    w_acc   = 1'b0;
    w_sel   = '1;
    for (int i = DIG_NUM - 1; i >= 0; i--) begin
      w_acc    = w_acc | (r_disp[4*i +: 4] != 4'd0);
      w_sel[i] = r_dig_idx != IW'(i);
      if (r_dig_idx == IW'(i)) begin
        w_nib   = r_disp[4*i +: 4];
        w_blank = LZ && (i > 0) && !w_acc;
      end
    end
  end
  // A strobe coinciding with frame end lands in the shadow after the old shadow is committed;
  // the later non-blocking write keeps pend set.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state   <= BLANK;
      r_div_cnt <= '0;
      r_dig_idx <= '0;
      r_shadow  <= '0;
      r_disp    <= '0;
      r_pend    <= 1'b0;
      sel       <= '1;
      seg       <= 8'hFF;
    end else begin
      r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
      if (w_div_end) r_dig_idx <= w_last_dig ? '0 : r_dig_idx + 1'b1;
      if (w_div_end && w_last_dig && r_pend) begin
        r_disp  <= r_shadow;
        r_pend  <= 1'b0;
        r_state <= SHOW;
      end
      if (bcd_vld) begin
        r_shadow <= bcd_data;
        r_pend   <= 1'b1;
      end
      sel <= w_sel;
      seg <= (r_state == SHOW && !w_blank) ? f_dec(w_nib) : 8'hFF;
    end
  end
endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Time-multiplexed 7-segment display driver that sits directly downstream of `bin2bcd`. It consumes the packed BCD result (`bcd_vld`/`bcd_data`), holds it in a shadow register and commits it to the display register only at frame boundaries, so a scan never shows half-old and half-new digits. It scans the digits one at a time and drives active-low digit-select and segment lines.

## Interface
- `DIG_NUM`, default 2: number of BCD digits / display positions; `bcd_data` is 4*`DIG_NUM` bits.
- `SCAN_DIV`, default 50000: `sclk` cycles each digit stays lit; must be ≥2.
- `sclk` in 1: system clock, all logic on the rising edge.
- `s_rst` in 1: synchronous, active-high reset.
- `bcd_vld` in 1: one-cycle strobe; `bcd_data` is valid in this cycle.
- `bcd_data` in 4*`DIG_NUM`: packed BCD, nibble 0 = least significant digit.
- `sel` out `DIG_NUM`: digit enable, active-low, one-hot-zero while scanning.
- `seg` out 8: segments, active-low; `seg[6:0]` = g..a, `seg[7]` = dp, held 1 (off).

## Operation
- `div_cnt` counts 0..`SCAN_DIV`-1 and wraps. `dig_idx` advances when `div_cnt`==`SCAN_DIV`-1 and wraps from `DIG_NUM`-1 to 0.
- Frame end: `div_cnt`==`SCAN_DIV`-1 and `dig_idx`==`DIG_NUM`-1.
- On `bcd_vld`: shadow <= `bcd_data` and pend <= 1. A later `bcd_vld` overwrites the shadow; the last value before frame end wins.
- At frame end with pend=1: disp <= shadow, pend <= 0, loaded <= 1.
- At frame end with `bcd_vld` in the same cycle: disp takes the old shadow (only if pend was 1), shadow takes the new data, pend stays 1.
- Two-state display FSM:
  - BLANK: after reset, until the first commit. All digits show 8'hFF.
  - SHOW: entered when loaded first becomes 1. Stays there until reset.
- Decoding of each nibble, active-low:
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90.
  - 10..15 (invalid) → BF ("-").
- `sel` keeps scanning in both states: `sel` = ~(1<<`dig_idx`).

## Timing
- Reset values (one edge after `s_rst`=1):
  - `div_cnt`=0, `dig_idx`=0, shadow=0, disp=0, pend=0, state BLANK.
  - `sel`={`DIG_NUM`{1'b1}}, `seg`=8'hFF.
- Reset mid-frame discards shadow, pend and disp. The display returns to BLANK.
- `sel` and `seg` are registered from the current `dig_idx`/disp and lag the counter state by 1 cycle. They always change together, so there is no ghosting.
- Latency from `bcd_vld` to visible digit:
  - Minimum 2 cycles (strobe one cycle before frame end).
  - Maximum `DIG_NUM`*`SCAN_DIV`+1 cycles.
- No back-pressure: `bcd_vld` is accepted every cycle.

## Configuration
- `BCD_SEG_LZ_BLANK_EN` defined: digit i>0 shows 8'hFF when disp nibbles i..`DIG_NUM`-1 are all 0. Digit 0 is never blanked. An invalid nibble counts as non-zero.
- Undefined: leading zeros show as C0.

## Test plan
Run all scenarios with `DIG_NUM`=2, `SCAN_DIV`=4.
- Reset, then idle 20 cycles → `sel` alternates 2'b10/2'b01 every 4 cycles, `seg`=FF throughout.
- `bcd_vld` with 8'h30 → after the next frame end, digit1 shows B0 and digit0 shows C0, repeating every 8 cycles.
- 8'h05 with macro defined → digit1=FF, digit0=92. Without macro → digit1=C0.
- 8'h30 then 8'h47 in consecutive cycles, both before frame end → only 99/F8 is ever shown, 30 never appears. Then 8'h12 exactly at frame end → the old shadow (47) is committed, and 8'h12 (F9/A4) appears one frame later.
- 8'h3C → digit1=B0, digit0=BF.
- `s_rst` pulse mid-frame while showing 30 → the next edge gives `sel`=11 and `seg`=FF, and the display stays blank until a new `bcd_vld` is committed.
